uart_in_buffer: RTL and testbench

UART_IN_BUFFER -- requirements
Module: uart_in_buffer

---
 rtl/uart_buf_pkg.sv | 14 +
 rtl/byte_fifo.sv | 67 ++++++
 rtl/uart_in_buffer.sv | 128 ++++++++++++
 tb/tb_uart_in_buffer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_buf_pkg.sv
// Shared types and constants for the UART receive buffer: read FSM states,
// default FIFO depth and word size in bytes.
package uart_buf_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_e;

    localparam int unsigned DEFAULT_DEPTH  = 16;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide circular FIFO. Pushes when full and pops when empty are ignored;
// the occupancy counter disambiguates full from empty.
module byte_fifo
    import uart_buf_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[head_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (do_push) tail_d = tail_q + PtrW'(1);
        if (do_pop)  head_d = head_q + PtrW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[tail_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_in_buffer.sv
// UART receive buffer: byte FIFO fed by the rx stage, a read FSM that packs
// one or four bytes little-endian for the CPU, and sticky drop flags.
module uart_in_buffer
    import uart_buf_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_ready_i,
    input  logic                     rx_ferr_i,
    input  logic                     rd_req_i,
    input  logic                     rd_word_i,
    input  logic                     clr_err_i,
    output logic [31:0]              rd_data_o,
    output logic                     rd_valid_o,
    output logic                     stall_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     ferr_seen_o
);

    state_e      state_q, state_d;
    logic        is_word_q, is_word_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] pack_q, pack_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        stall_q, stall_d;
    logic        overflow_q, overflow_d;
    logic        ferr_q, ferr_d;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [1:0]  last_idx;
    logic        ovf_set, ferr_set;

    assign fifo_push = rx_ready_i && !rx_ferr_i;
    assign fifo_pop  = (state_q == StCollect) && !fifo_empty;
    assign ovf_set   = fifo_push && fifo_full;
    assign ferr_set  = rx_ready_i && rx_ferr_i;
    assign last_idx  = is_word_q ? 2'(BYTES_PER_WORD - 1) : 2'd0;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (rx_data_i),
        .rdata_o (fifo_rdata),
        .count_o (count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        is_word_d  = is_word_q;
        idx_d      = idx_q;
        pack_d     = pack_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        stall_d    = stall_q;
        unique case (state_q)
            StIdle: begin
                if (rd_req_i) begin
                    state_d   = StCollect;
                    is_word_d = rd_word_i;
                    idx_d     = '0;
                    pack_d    = '0;
                    stall_d   = 1'b1;
                end
            end
            StCollect: begin
                if (fifo_pop) begin
                    pack_d[{idx_q, 3'b000} +: 8] = fifo_rdata;
                    if (idx_q == last_idx) state_d = StDone;
                    else                   idx_d   = idx_q + 2'd1;
                end
            end
            StDone: begin
                rd_valid_d = 1'b1;
                rd_data_d  = pack_q;
                stall_d    = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A set in the same cycle as clr_err wins over the clear.
    assign overflow_d = ovf_set  ? 1'b1 : (clr_err_i ? 1'b0 : overflow_q);
    assign ferr_d     = ferr_set ? 1'b1 : (clr_err_i ? 1'b0 : ferr_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            is_word_q  <= 1'b0;
            idx_q      <= '0;
            pack_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_word_q  <= is_word_d;
            idx_q      <= idx_d;
            pack_q     <= pack_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign stall_o     = stall_q;
    assign overflow_o  = overflow_q;
    assign ferr_seen_o = ferr_q;

endmodule

// File: tb/tb_uart_in_buffer.sv
// Self-checking bench for uart_in_buffer against a queue-based model of the
// buffer contents, sticky flags and read latency.
module tb_uart_in_buffer;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready = 1'b0;
    logic        rx_ferr = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_word = 1'b0;
    logic        clr_err = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        stall;
    logic [4:0]  count;
    logic        overflow;
    logic        ferr_seen;

    int n_tests = 0;
    int n_fail = 0;

    logic [7:0] model_q[$];
    bit         m_ovf = 1'b0;
    bit         m_ferr = 1'b0;

    uart_in_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_data_i   (rx_data),
        .rx_ready_i  (rx_ready),
        .rx_ferr_i   (rx_ferr),
        .rd_req_i    (rd_req),
        .rd_word_i   (rd_word),
        .clr_err_i   (clr_err),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .stall_o     (stall),
        .count_o     (count),
        .overflow_o  (overflow),
        .ferr_seen_o (ferr_seen)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the byte is presented for exactly one rising edge.
    task automatic push_byte(input logic [7:0] b, input logic ferr);
        rx_data = b;
        rx_ready = 1'b1;
        rx_ferr = ferr;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_ferr = 1'b0;
        if (ferr) m_ferr = 1'b1;
        else if (model_q.size() == DEPTH) m_ovf = 1'b1;
        else model_q.push_back(b);
    endtask

    task automatic model_pop(input logic w, output logic [31:0] exp);
        int nb;
        nb = w ? 4 : 1;
        exp = '0;
        for (int k = 0; k < nb; k++) exp = exp | (32'(model_q.pop_front()) << (8 * k));
    endtask

    // Issues a read and waits for rd_valid; lat = -1 on timeout.
    task automatic do_read(input logic w, output logic [31:0] data, output int lat,
                           output bit stall_ok);
        rd_req = 1'b1;
        rd_word = w;
        @(negedge clk);
        rd_req = 1'b0;
        lat = 1;
        stall_ok = 1'b1;
        while (!rd_valid && lat < 200) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        data = rd_data;
        if (rd_valid !== 1'b1) lat = -1;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ovf = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({rd_valid, stall, overflow, ferr_seen, count} !== 9'd0 || rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b stall=%b ovf=%b ferr=%b count=%0d data=%h, expected all 0",
                     rd_valid, stall, overflow, ferr_seen, count, rd_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_read();
        logic [31:0] d, exp;
        int lat;
        bit sok;
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        push_byte(8'h33, 1'b0);
        push_byte(8'h44, 1'b0);
        do_read(1'b1, d, lat, sok);
        model_pop(1'b1, exp);
        n_tests++;
        if (d !== exp || exp !== 32'h44332211) begin
            n_fail++;
            $display("FAIL word_read_data: got %h expected %h", d, exp);
        end
        n_tests++;
        if (lat !== 6 || !sok) begin
            n_fail++;
            $display("FAIL word_read_latency: got %0d stall_ok=%0d expected 6 stall_ok=1", lat, sok);
        end
        n_tests++;
        if (count !== 5'(model_q.size())) begin
            n_fail++;
            $display("FAIL word_read_count: got %0d expected %0d", count, model_q.size());
        end
    endtask

    task automatic test_wait_empty();
        logic [7:0]  bytes [4];
        logic [31:0] exp, got;
        int bad_stall, pulses;
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        bad_stall = 0;
        pulses = 0;
        got = '0;
        rd_req = 1'b1;
        rd_word = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (19) begin
                if (stall !== 1'b1 || rd_valid !== 1'b0) bad_stall++;
                @(negedge clk);
            end
            push_byte(bytes[i], 1'b0);
        end
        for (int c = 0; c < 12; c++) begin
            if (rd_valid === 1'b1) begin
                pulses++;
                got = rd_data;
            end else if (pulses == 0 && stall !== 1'b1) begin
                bad_stall++;
            end
            @(negedge clk);
        end
        model_pop(1'b1, exp);
        n_tests++;
        if (bad_stall != 0) begin
            n_fail++;
            $display("FAIL wait_stall_held: got %0d bad cycles expected 0", bad_stall);
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL wait_valid_pulses: got %0d expected 1", pulses);
        end
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL wait_data: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d, exp;
        int lat, bad_data, bad_lat;
        bit sok;
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
        // Dropped byte and clear in the same cycle: the set must win.
        rx_data = 8'h10;
        rx_ready = 1'b1;
        clr_err = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        clr_err = 1'b0;
        m_ovf = 1'b1;
        n_tests++;
        if (count !== 5'd16 || overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL overflow_full: got count=%0d ovf=%b expected count=16 ovf=1", count, overflow);
        end
        bad_data = 0;
        bad_lat = 0;
        for (int i = 0; i < 16; i++) begin
            do_read(1'b0, d, lat, sok);
            model_pop(1'b0, exp);
            if (d !== exp || d !== 32'(i)) bad_data++;
            if (lat !== 3 || !sok) bad_lat++;
        end
        n_tests++;
        if (bad_data != 0) begin
            n_fail++;
            $display("FAIL overflow_byte_data: got %0d bad reads expected 0", bad_data);
        end
        n_tests++;
        if (bad_lat != 0) begin
            n_fail++;
            $display("FAIL byte_read_latency: got %0d bad reads expected 0", bad_lat);
        end
        pulse_clr();
        n_tests++;
        if (overflow !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL overflow_clear: got ovf=%b count=%0d expected ovf=0 count=0", overflow, count);
        end
    endtask

    task automatic test_ferr();
        logic [31:0] d, exp;
        int lat;
        bit sok;
        push_byte(8'h55, 1'b1);
        push_byte(8'h66, 1'b0);
        n_tests++;
        if (ferr_seen !== 1'b1 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL ferr_drop: got ferr=%b count=%0d expected ferr=1 count=1", ferr_seen, count);
        end
        do_read(1'b0, d, lat, sok);
        model_pop(1'b0, exp);
        n_tests++;
        if (d !== exp || d !== 32'h66) begin
            n_fail++;
            $display("FAIL ferr_byte_read: got %h expected %h", d, exp);
        end
        pulse_clr();
        n_tests++;
        if (ferr_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_clear: got %b expected 0", ferr_seen);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d, exp;
        int lat, bad;
        bit sok;
        bad = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) push_byte(8'($urandom_range(0, 255)), 1'b0);
            for (int i = 0; i < 12; i++) begin
                do_read(1'b0, d, lat, sok);
                model_pop(1'b0, exp);
                if (d !== exp || lat < 0) bad++;
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wrap_order: got %0d bad reads expected 0", bad);
        end
        n_tests++;
        if (overflow !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_flags: got ovf=%b count=%0d expected ovf=0 count=0", overflow, count);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, exp;
        int lat, r, bad_data, bad_lat, bad_state;
        bit sok;
        logic w;
        bad_data = 0;
        bad_lat = 0;
        bad_state = 0;
        for (int it = 0; it < 120; it++) begin
            r = int'($urandom_range(0, 9));
            w = 1'($urandom_range(0, 1));
            if (r == 9) begin
                pulse_clr();
            end else if (r >= 5 && model_q.size() >= (w ? 4 : 1)) begin
                do_read(w, d, lat, sok);
                model_pop(w, exp);
                if (d !== exp) bad_data++;
                if (lat !== (w ? 6 : 3) || !sok) bad_lat++;
            end else begin
                push_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
            end
            if (count !== 5'(model_q.size()) || overflow !== m_ovf || ferr_seen !== m_ferr)
                bad_state++;
        end
        n_tests++;
        if (bad_data != 0) begin
            n_fail++;
            $display("FAIL random_data: got %0d bad reads expected 0", bad_data);
        end
        n_tests++;
        if (bad_lat != 0) begin
            n_fail++;
            $display("FAIL random_latency: got %0d bad reads expected 0", bad_lat);
        end
        n_tests++;
        if (bad_state != 0) begin
            n_fail++;
            $display("FAIL random_state: got %0d bad steps expected 0", bad_state);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d, exp;
        int lat, pulses;
        bit sok;
        pulses = 0;
        push_byte(8'h12, 1'b0);
        push_byte(8'h34, 1'b0);
        rd_req = 1'b1;
        rd_word = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        repeat (3) begin
            if (rd_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        model_q.delete();
        m_ovf = 1'b0;
        m_ferr = 1'b0;
        #1;
        n_tests++;
        if ({rd_valid, stall, overflow, ferr_seen, count} !== 9'd0 || rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_read_reset: got valid=%b stall=%b ovf=%b ferr=%b count=%0d data=%h, expected all 0",
                     rd_valid, stall, overflow, ferr_seen, count, rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            if (rd_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL mid_read_no_valid: got %0d pulses expected 0", pulses);
        end
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)), 1'b0);
        do_read(1'b1, d, lat, sok);
        model_pop(1'b1, exp);
        n_tests++;
        if (d !== exp || lat !== 6) begin
            n_fail++;
            $display("FAIL post_reset_word: got %h lat=%0d expected %h lat=6", d, lat, exp);
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_wait_empty();
        test_overflow();
        test_ferr();
        test_wrap();
        test_random();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
